// File: rtl/ssriscv_pkg.sv
// Shared definitions for the ssriscv retirement-trace buffer.
// Contents: trace FSM state encoding, stop-cause codes, the `j .` opcode
// used to detect a self-loop, and a saturating 32-bit increment helper.
package ssriscv_pkg;

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } trace_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE      = 2'b00,
      CAUSE_BUDGET    = 2'b01,
      CAUSE_SELF_LOOP = 2'b10,
      CAUSE_FULL      = 2'b11
   } stop_cause_e;

   // jal x0, 0 : the canonical "spin here forever" end-of-program marker
   localparam logic [31:0] JAL_SELF = 32'h0000_006f;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hffff_ffff) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ssriscv_trace_ram.sv
// Trace record storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by
// the pointers in the parent.
// Ports:
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
module ssriscv_trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 102
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Asynchronous read port
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ssriscv_commit_trace.sv
// Retirement-trace buffer for ssriscv_cpu_top. Records one entry per
// retired instruction into a circular buffer, stops on a cycle budget, a
// `j .` self-loop or a full buffer, then drains oldest-first over
// valid/ready.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   commit_valid/pc/instr/rd/we/wdata  retirement record input
//   out_ready                        consumer accepts head record
//   out_valid, out_pc/instr/rd/we/wdata  head record (combinational)
//   level                            occupancy
//   cycle_cnt                        CAPTURE cycle counter (saturating)
//   overflow                         sticky: a record was overwritten
//   stop_cause                       why capture ended
//   done                             DONE state reached
module ssriscv_commit_trace
   import ssriscv_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_CYCLES = 150,
   parameter bit          WRAP_MODE  = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     commit_valid,
   input  logic [XLEN-1:0]          commit_pc,
   input  logic [31:0]              commit_instr,
   input  logic [4:0]               commit_rd,
   input  logic                     commit_we,
   input  logic [XLEN-1:0]          commit_wdata,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [4:0]               out_rd,
   output logic                     out_we,
   output logic [XLEN-1:0]          out_wdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic [31:0]              cycle_cnt,
   output logic                     overflow,
   output logic [1:0]               stop_cause,
   output logic                     done
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned REC_W = XLEN + 32 + 5 + 1 + XLEN;

   // The counter holds at MAX_CYCLES-1; the CAPTURE cycle that finds it
   // there is the last of MAX_CYCLES capture cycles.
   localparam bit          BUDGET_EN   = (MAX_CYCLES != 0);
   localparam logic [31:0] BUDGET_LAST = BUDGET_EN ? 32'(MAX_CYCLES - 1) : 32'hffff_ffff;

   trace_state_e      state_q, state_d;
   stop_cause_e       cause_q, cause_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              ovf_q, ovf_d;

   logic              full;
   logic              pop;
   logic              do_push;
   logic              do_adv;
   logic              drop_full;
   logic              budget_hit;
   logic              rec_we;
   logic [REC_W-1:0]  wrec;
   logic [REC_W-1:0]  rrec;

   // x0 is architecturally never written, so record it as no write
   assign rec_we = commit_we && (commit_rd != 5'd0);
   assign wrec   = {commit_pc, commit_instr, commit_rd, rec_we, commit_wdata};

   ssriscv_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (do_push && rst_n),
      .waddr_i (wptr_q),
      .wdata_i (wrec),
      .raddr_i (rptr_q),
      .rdata_o (rrec)
   );

   // Head record and handshake
   assign full      = (level_q == LVL_W'(DEPTH));
   assign out_valid = (state_q != ST_DONE) && (level_q != '0);
   assign pop       = out_valid && out_ready;
   assign {out_pc, out_instr, out_rd, out_we, out_wdata} = rrec;

   assign level      = level_q;
   assign cycle_cnt  = cnt_q;
   assign overflow   = ovf_q;
   assign stop_cause = cause_q;
   assign done       = (state_q == ST_DONE);

   // Next-state: FSM, pointers, occupancy, counters, stop logic
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      level_d    = level_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      do_push    = 1'b0;
      do_adv     = pop;
      drop_full  = 1'b0;
      budget_hit = 1'b0;

      unique case (state_q)
         ST_CAPTURE: begin
            budget_hit = BUDGET_EN && (cnt_q >= BUDGET_LAST);
            cnt_d      = budget_hit ? cnt_q : sat_inc32(cnt_q);
            // A same-cycle pop frees a slot, so that case is never a drop
            drop_full  = commit_valid && full && !pop && !WRAP_MODE;

            if (commit_valid && !drop_full) begin
               do_push = 1'b1;
               // Overwrite: the oldest entry is discarded by advancing rptr
               if (full && !pop) begin
                  do_adv = 1'b1;
                  ovf_d  = 1'b1;
               end
            end

            if (drop_full) begin
               cause_d = CAUSE_FULL;
               state_d = ST_DRAIN;
            end else if (commit_valid && (commit_instr == JAL_SELF)) begin
               cause_d = CAUSE_SELF_LOOP;
               state_d = ST_DRAIN;
            end else if (budget_hit) begin
               cause_d = CAUSE_BUDGET;
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Empty now, or emptied by this cycle's pop
            if (level_q == LVL_W'(pop)) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
         end

         default: begin
            state_d = ST_CAPTURE;
         end
      endcase

      if (do_push) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (do_adv) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      if (do_push && !do_adv) begin
         level_d = level_q + LVL_W'(1);
      end else if (!do_push && do_adv) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // State registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_CAPTURE;
         cause_q <= CAUSE_NONE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ssriscv_commit_trace.sv
// Bench for ssriscv_commit_trace. Four instances share one stimulus bus:
//   0: DEPTH=16 WRAP=1 MAX=150   1: DEPTH=4 WRAP=1 MAX=0
//   2: DEPTH=4  WRAP=0 MAX=0     3: DEPTH=16 WRAP=1 MAX=10
// Only the instance under test (cur) is compared against a queue model.
module tb_ssriscv_commit_trace;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] wdata;
   } rec_t;

   logic        clk;
   logic        rst_n;
   logic        cv;
   logic [31:0] cpc;
   logic [31:0] cinstr;
   logic [4:0]  crd;
   logic        cwe;
   logic [31:0] cwd;
   logic        rdy;

   logic        ov    [4];
   logic [31:0] opc   [4];
   logic [31:0] oins  [4];
   logic [4:0]  ord   [4];
   logic        owe   [4];
   logic [31:0] owd   [4];
   logic [4:0]  lvl   [4];
   logic [31:0] cnt   [4];
   logic        ovf   [4];
   logic [1:0]  cause [4];
   logic        dn    [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned D = (g == 0 || g == 3) ? 16 : 4;
      localparam int unsigned M = (g == 0) ? 150 : ((g == 3) ? 10 : 0);
      localparam bit          W = (g == 2) ? 1'b0 : 1'b1;
      logic [$clog2(D):0] lvl_w;
      ssriscv_commit_trace #(
         .XLEN(32), .DEPTH(D), .MAX_CYCLES(M), .WRAP_MODE(W)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .commit_valid(cv), .commit_pc(cpc), .commit_instr(cinstr),
         .commit_rd(crd), .commit_we(cwe), .commit_wdata(cwd),
         .out_ready(rdy), .out_valid(ov[g]), .out_pc(opc[g]),
         .out_instr(oins[g]), .out_rd(ord[g]), .out_we(owe[g]),
         .out_wdata(owd[g]), .level(lvl_w), .cycle_cnt(cnt[g]),
         .overflow(ovf[g]), .stop_cause(cause[g]), .done(dn[g])
      );
      assign lvl[g] = 5'(lvl_w);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errs;
   int          checks;
   int          cur;
   int          n_out;
   rec_t        mq [$];
   int          m_ph;
   logic [31:0] m_cnt;
   logic        m_ovf;
   logic [1:0]  m_cause;

   function automatic int unsigned dep(input int k);
      return (k == 0 || k == 3) ? 16 : 4;
   endfunction
   function automatic int unsigned maxc(input int k);
      return (k == 0) ? 150 : ((k == 3) ? 10 : 0);
   endfunction
   function automatic bit wrapm(input int k);
      return (k != 2);
   endfunction

   function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] ins);
      rec_t r;
      r.pc    = pc;
      r.instr = ins;
      r.rd    = pc[6:2] + 5'd1;
      r.we    = 1'b1;
      r.wdata = pc ^ 32'ha5a5_0000;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: buffer is a queue, phases 0=capture 1=drain 2=done
   task automatic mstep(input bit v, input rec_t r, input bit rd_b, input bit rn);
      rec_t rr;
      bit   pop, full, budget;
      if (!rn) begin
         mq.delete();
         m_ph = 0; m_cnt = '0; m_ovf = 1'b0; m_cause = 2'b00;
         return;
      end
      pop   = (m_ph != 2) && (mq.size() > 0) && rd_b;
      rr    = r;
      rr.we = r.we && (r.rd != 5'd0);
      if (m_ph == 0) begin
         full   = (mq.size() == dep(cur));
         budget = (maxc(cur) != 0) && (m_cnt >= 32'(maxc(cur) - 1));
         if (!budget && m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 32'd1;
         if (pop) void'(mq.pop_front());
         if (v) begin
            if (full && !pop) begin
               if (wrapm(cur)) begin
                  void'(mq.pop_front());
                  mq.push_back(rr);
                  m_ovf = 1'b1;
               end else begin
                  m_cause = 2'b11;
               end
            end else begin
               mq.push_back(rr);
            end
            if (m_cause == 2'b00 && r.instr == 32'h0000_006f) m_cause = 2'b10;
         end
         if (m_cause == 2'b00 && budget) m_cause = 2'b01;
         if (m_cause != 2'b00) m_ph = 1;
      end else if (m_ph == 1) begin
         if (pop) void'(mq.pop_front());
         if (mq.size() == 0) m_ph = 2;
      end
   endtask

   task automatic check_model();
      bit ev;
      ev = (m_ph != 2) && (mq.size() > 0);
      chk("out_valid", 32'(ov[cur]), 32'(ev));
      chk("level", 32'(lvl[cur]), 32'(mq.size()));
      chk("cycle_cnt", cnt[cur], m_cnt);
      chk("overflow", 32'(ovf[cur]), 32'(m_ovf));
      chk("stop_cause", 32'(cause[cur]), 32'(m_cause));
      chk("done", 32'(dn[cur]), 32'(m_ph == 2));
      if (ev) begin
         chk("out_pc", opc[cur], mq[0].pc);
         chk("out_instr", oins[cur], mq[0].instr);
         chk("out_rd", 32'(ord[cur]), 32'(mq[0].rd));
         chk("out_we", 32'(owe[cur]), 32'(mq[0].we));
         chk("out_wdata", owd[cur], mq[0].wdata);
      end
   endtask

   task automatic step(input bit v, input rec_t r, input bit rd_b, input bit rn);
      @(negedge clk);
      if (rn && rst_n && ov[cur] && rd_b) n_out++;
      rst_n = rn; cv = v; cpc = r.pc; cinstr = r.instr; crd = r.rd;
      cwe = r.we; cwd = r.wdata; rdy = rd_b;
      mstep(v, r, rd_b, rn);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      step(1'b0, mk(32'h0, 32'h13), 1'b0, 1'b0);
      step(1'b0, mk(32'h0, 32'h13), 1'b0, 1'b0);
   endtask

   initial begin
      rec_t r;
      errs = 0; checks = 0; cur = 0; n_out = 0;
      rst_n = 1'b0; cv = 1'b0; cpc = '0; cinstr = '0; crd = '0;
      cwe = 1'b0; cwd = '0; rdy = 1'b0;
      mstep(1'b0, mk(32'h0, 32'h13), 1'b0, 1'b0);

      // Basic capture and drain
      cur = 0;
      do_reset();
      chk("rst_level", 32'(lvl[0]), 32'd0);
      chk("rst_valid", 32'(ov[0]), 32'd0);
      chk("rst_cause", 32'(cause[0]), 32'd0);
      chk("rst_done", 32'(dn[0]), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, mk(32'(4 * i), 32'h13), 1'b0, 1'b1);
      chk("t1_level3", 32'(lvl[0]), 32'd3);
      chk("t1_head0", opc[0], 32'h0);
      step(1'b0, mk(32'h0, 32'h13), 1'b1, 1'b1);
      chk("t1_head4", opc[0], 32'h4);
      step(1'b0, mk(32'h0, 32'h13), 1'b1, 1'b1);
      chk("t1_head8", opc[0], 32'h8);
      step(1'b0, mk(32'h0, 32'h13), 1'b1, 1'b1);
      chk("t1_empty", 32'(ov[0]), 32'd0);

      // Wrap overwrite, DEPTH=4
      cur = 1;
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, mk(32'(4 * i), 32'h13), 1'b0, 1'b1);
      chk("t2_overflow", 32'(ovf[1]), 32'd1);
      chk("t2_level", 32'(lvl[1]), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_order", opc[1], 32'h8 + 32'(4 * i));
         step(1'b0, mk(32'h0, 32'h13), 1'b1, 1'b1);
      end
      chk("t2_drained", 32'(ov[1]), 32'd0);

      // Stop when full, DEPTH=4
      cur = 2;
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, mk(32'(4 * i), 32'h13), 1'b0, 1'b1);
      chk("t3_cause", 32'(cause[2]), 32'd3);
      chk("t3_level", 32'(lvl[2]), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_order", opc[2], 32'(4 * i));
         step(1'b1, mk(32'h100, 32'h13), 1'b1, 1'b1);
      end
      chk("t3_done", 32'(dn[2]), 32'd1);

      // Self-loop stop
      cur = 0;
      do_reset();
      step(1'b1, mk(32'h10, 32'h13), 1'b0, 1'b1);
      step(1'b1, mk(32'h20, 32'h0000_006f), 1'b0, 1'b1);
      chk("t4_cause", 32'(cause[0]), 32'd2);
      chk("t4_level", 32'(lvl[0]), 32'd2);
      for (int i = 0; i < 4; i++) step(1'b1, mk(32'h30, 32'h13), 1'b1, 1'b1);
      chk("t4_done", 32'(dn[0]), 32'd1);
      chk("t4_cnt_frozen", cnt[0], 32'd2);

      // Cycle budget, MAX_CYCLES=10, continuous commits and ready
      cur = 3;
      do_reset();
      n_out = 0;
      for (int i = 0; i < 40 && !dn[3]; i++) step(1'b1, mk(32'(4 * i), 32'h13), 1'b1, 1'b1);
      chk("t5_done", 32'(dn[3]), 32'd1);
      chk("t5_cause", 32'(cause[3]), 32'd1);
      chk("t5_cnt", cnt[3], 32'd9);
      chk("t5_records", 32'(n_out), 32'd10);

      // Reset during DRAIN
      cur = 0;
      do_reset();
      step(1'b1, mk(32'h0, 32'h13), 1'b0, 1'b1);
      step(1'b1, mk(32'h4, 32'h0000_006f), 1'b0, 1'b1);
      chk("t6_level2", 32'(lvl[0]), 32'd2);
      step(1'b0, mk(32'h0, 32'h13), 1'b0, 1'b0);
      chk("t6_level0", 32'(lvl[0]), 32'd0);
      chk("t6_done0", 32'(dn[0]), 32'd0);
      chk("t6_cause0", 32'(cause[0]), 32'd0);
      step(1'b1, mk(32'h40, 32'h13), 1'b0, 1'b1);
      chk("t6_capture", opc[0], 32'h40);

      // Random traffic against the model on instances 0..2
      for (int k = 0; k < 3; k++) begin
         cur = k;
         do_reset();
         for (int i = 0; i < 180; i++) begin
            r.pc    = $urandom;
            r.instr = ($urandom_range(0, 39) == 0) ? 32'h0000_006f : $urandom;
            r.rd    = 5'($urandom);
            r.we    = 1'($urandom_range(0, 1));
            r.wdata = $urandom;
            step(1'($urandom_range(0, 1)), r, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 49) != 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
